uart_time_reporter: RTL and testbench
=====================================

Name: uart_time_reporter

Overview:
Sequencer that turns a measured lap time into an ASCII line and feeds it byte by byte to the 1-byte UART transmitter engine (8-N-1). On a one-cycle send request it latches a binary millisecond count and converts it to 7 BCD digits. It then emits the fixed 10-byte frame "DDDD.DDD\r\n" using a start-pulse/busy handshake with the UART engine. It sits between the stopwatch timing core and the UART engine, and is the only driver of the engine's start and data inputs.

Parameters:
TIME_W, 24, width of the binary millisecond input
MAX_MS, 9_999_999, saturation ceiling; larger inputs are reported as MAX_MS

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
i_send  input  1  one-cycle pulse requesting a report
i_time_ms  input  TIME_W  lap time in ms; sampled only in the cycle i_send is accepted
o_tx_start  output  1  one-cycle start pulse to the UART engine
o_tx_data  output  8  byte to the UART engine; valid while o_tx_start=1
i_tx_busy  input  1  UART engine busy flag
o_busy  output  1  1 from acceptance until frame complete
o_done  output  1  one-cycle pulse after the last byte (LF) has finished
o_overrun  output  1  one-cycle pulse when i_send arrives while o_busy=1

Behaviour:
- Clock and reset: single clock clk; reset synchronous, active-high.
- Reset values: o_tx_start=0, o_tx_data=8'h00, o_busy=0, o_done=0, o_overrun=0, state=S_IDLE, byte index=0.
- Reset mid-frame: abort immediately and return to S_IDLE. No further o_tx_start is issued. A byte already handed to the engine completes on its own.
- Frame format, in send order:
  - Bytes 0-3: D6 D5 D4 D3 as ASCII '0'+d.
  - Byte 4: '.' (8'h2E).
  - Bytes 5-7: D2 D1 D0.
  - Byte 8: CR (8'h0D). Byte 9: LF (8'h0A).
  - Leading zeros are always sent; the frame is always exactly 10 bytes.
- Saturation: if i_time_ms > MAX_MS, convert MAX_MS instead.
- State machine:
  - S_IDLE: o_busy=0. On i_send: latch the saturated value, o_busy<=1, go to S_CONV.
  - S_CONV: sequential double-dabble, one input bit per cycle, exactly TIME_W cycles, then go to S_LOAD.
  - S_LOAD: one cycle. Drive o_tx_start=1 and o_tx_data=byte[idx], go to S_WAIT_ACK.
  - S_WAIT_ACK: wait until i_tx_busy=1 (the engine raises busy the cycle after start), then go to S_WAIT_DONE. o_tx_start is never re-asserted here.
  - S_WAIT_DONE: wait for i_tx_busy=0.
    - If idx==9: o_done<=1, o_busy<=0, idx<=0, go to S_IDLE.
    - Otherwise: idx<=idx+1, go to S_LOAD.
- Latency: with i_send sampled at cycle 0, o_busy=1 from cycle 1 and the first o_tx_start occurs at cycle TIME_W+1. Each subsequent start follows the previous byte's busy fall by exactly 1 cycle.
- Request handling:
  - i_send while o_busy=1 (including the o_done cycle's state): ignored. o_overrun pulses the next cycle; latched data is unaffected.
  - i_send in the same cycle o_done is asserted: state is already S_IDLE, so the request is accepted.
- o_tx_start is high at most 1 cycle per byte. o_tx_data holds its value until the next S_LOAD.
- No timeout: if i_tx_busy never rises, the block stays in S_WAIT_ACK until reset.

Decomposition:
- Package uart_report_pkg:
  - ASCII constants: ASCII_0=8'h30, ASCII_DOT=8'h2E, ASCII_CR=8'h0D, ASCII_LF=8'h0A.
  - FRAME_LEN=10.
  - State encoding S_IDLE, S_CONV, S_LOAD, S_WAIT_ACK, S_WAIT_DONE.
- Sub-module bin2bcd_seq:
  - Interface: start pulse, TIME_W-bit input, 7x4-bit BCD output, done pulse after TIME_W cycles.
  - Instantiated once; drives the S_CONV exit.

Test Plan:
- i_time_ms=1_234_567 with i_send, real uart_tx in loop (CLKS_PER_BIT=4) -> serial bytes 31 32 33 34 2E 35 36 37 0D 0A; one o_done pulse; o_busy low after LF stop bit.
- i_time_ms=0 -> "0000.000\r\n" (30 30 30 30 2E 30 30 30 0D 0A); first o_tx_start exactly 25 cycles after i_send.
- i_time_ms=24'hFFFFFF (16_777_215) -> saturated "9999.999\r\n"; i_time_ms=9_999_999 -> same frame.
- i_send pulsed during byte 3 with a different time -> o_overrun pulses once; frame continues unchanged; no extra bytes.
- reset asserted during S_WAIT_DONE of byte 5 -> all outputs return to reset values next cycle; no further o_tx_start; a new i_send afterward yields a complete correct frame.
- i_send in the same cycle as o_done -> a second frame is accepted; o_overrun=0; both frames are complete and back-to-back.

Source files
------------

// File: rtl/uart_time_reporter_pkg.sv
// Shared constants, state encoding and frame byte helper for the UART time reporter.
package uart_report_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned BCD_DIGITS = 7;
    localparam int unsigned BCD_W      = 4 * BCD_DIGITS;
    localparam int unsigned FRAME_LEN  = 10;
    localparam int unsigned IDX_W      = 4;

    localparam logic [BYTE_W-1:0] ASCII_0   = 8'h30;
    localparam logic [BYTE_W-1:0] ASCII_DOT = 8'h2E;
    localparam logic [BYTE_W-1:0] ASCII_CR  = 8'h0D;
    localparam logic [BYTE_W-1:0] ASCII_LF  = 8'h0A;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONV,
        S_LOAD,
        S_WAIT_ACK,
        S_WAIT_DONE
    } state_t;

    // Byte idx of "DDDD.DDD\r\n"; bcd[27:24] is the most significant digit.
    function automatic logic [BYTE_W-1:0] frame_byte(input logic [IDX_W-1:0] idx,
                                                     input logic [BCD_W-1:0] bcd);
        logic [BYTE_W-1:0] b;
        case (idx)
            4'd0:    b = ASCII_0 + BYTE_W'(bcd[27:24]);
            4'd1:    b = ASCII_0 + BYTE_W'(bcd[23:20]);
            4'd2:    b = ASCII_0 + BYTE_W'(bcd[19:16]);
            4'd3:    b = ASCII_0 + BYTE_W'(bcd[15:12]);
            4'd4:    b = ASCII_DOT;
            4'd5:    b = ASCII_0 + BYTE_W'(bcd[11:8]);
            4'd6:    b = ASCII_0 + BYTE_W'(bcd[7:4]);
            4'd7:    b = ASCII_0 + BYTE_W'(bcd[3:0]);
            4'd8:    b = ASCII_CR;
            4'd9:    b = ASCII_LF;
            default: b = '0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_time_reporter_if.sv
// Byte handshake between the reporter (master) and the UART transmit engine (slave).
//   o_tx_start : one-cycle start pulse from the reporter
//   o_tx_data  : byte to transmit, valid while o_tx_start=1
//   i_tx_busy  : engine busy flag, rises the cycle after start
interface uart_time_reporter_if;
    import uart_report_pkg::*;

    logic              o_tx_start;
    logic [BYTE_W-1:0] o_tx_data;
    logic              i_tx_busy;

    modport master (output o_tx_start, output o_tx_data, input i_tx_busy);
    modport slave  (input o_tx_start, input o_tx_data, output i_tx_busy);
endinterface

// File: rtl/uart_time_reporter_bin2bcd.sv
// Sequential double-dabble converter, one input bit per cycle.
//   clk, reset : clock, synchronous active-high reset
//   start      : loads bin and performs the first shift in the same cycle
//   bin        : binary value to convert
//   bcd        : 7 BCD digits, stable after done until the next start
//   done       : one-cycle pulse once all TIME_W bits have been shifted in
module bin2bcd_seq
    import uart_report_pkg::*;
#(
    parameter int unsigned TIME_W = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [TIME_W-1:0] bin,
    output logic [BCD_W-1:0]  bcd,
    output logic              done
);

    localparam int unsigned CNT_W = $clog2(TIME_W + 1);

    logic [TIME_W-1:0] shreg;
    logic [CNT_W-1:0]  cnt;
    logic              running;

    // Add-3 correction on every digit >= 5, then shift the next bit in.
    function automatic logic [BCD_W-1:0] dd_step(input logic [BCD_W-1:0] cur,
                                                 input logic bit_in);
        logic [BCD_W-1:0] adj;
        adj = cur;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (adj[d*4 +: 4] >= 4'd5) begin
                adj[d*4 +: 4] = adj[d*4 +: 4] + 4'd3;
            end
        end
        return {adj[BCD_W-2:0], bit_in};
    endfunction

    // Start counts as shift 1, so done lands exactly TIME_W cycles after start.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg   <= '0;
            cnt     <= '0;
            running <= 1'b0;
            bcd     <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                bcd     <= dd_step('0, bin[TIME_W-1]);
                shreg   <= bin << 1;
                cnt     <= CNT_W'(1);
                running <= 1'b1;
            end else if (running) begin
                bcd   <= dd_step(bcd, shreg[TIME_W-1]);
                shreg <= shreg << 1;
                cnt   <= cnt + CNT_W'(1);
                if (cnt == CNT_W'(TIME_W - 1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_time_reporter.sv
// Converts a millisecond lap time into "DDDD.DDD\r\n" and feeds it to a UART engine.
//   clk, reset : clock, synchronous active-high reset
//   i_send     : one-cycle report request
//   i_time_ms  : lap time, sampled only when i_send is accepted
//   tx         : start/data/busy handshake to the UART engine (master side)
//   o_busy     : high from acceptance until the frame is complete
//   o_done     : one-cycle pulse after the LF byte has finished
//   o_overrun  : one-cycle pulse when i_send arrives while busy
module uart_time_reporter
    import uart_report_pkg::*;
#(
    parameter int unsigned TIME_W = 24,
    parameter int unsigned MAX_MS = 9_999_999
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_send,
    input  logic [TIME_W-1:0]    i_time_ms,
    uart_time_reporter_if.master tx,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_overrun
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [TIME_W-1:0]  sat_ms_c;
    logic               conv_start_c;
    logic               conv_done;
    logic [BCD_W-1:0]   bcd;

    assign sat_ms_c     = (i_time_ms > TIME_W'(MAX_MS)) ? TIME_W'(MAX_MS) : i_time_ms;
    assign conv_start_c = (state == S_IDLE) && i_send;

    // The converter captures the saturated value on acceptance and holds the digits.
    bin2bcd_seq #(.TIME_W(TIME_W)) u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (conv_start_c),
        .bin   (sat_ms_c),
        .bcd   (bcd),
        .done  (conv_done)
    );

    // Frame sequencer; start/data are registered on entry to S_LOAD.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            idx           <= '0;
            tx.o_tx_start <= 1'b0;
            tx.o_tx_data  <= '0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_overrun     <= 1'b0;
        end else begin
            tx.o_tx_start <= 1'b0;
            o_done        <= 1'b0;
            o_overrun     <= i_send && o_busy;
            case (state)
                S_IDLE: begin
                    if (i_send) begin
                        o_busy <= 1'b1;
                        idx    <= '0;
                        state  <= S_CONV;
                    end
                end
                S_CONV: begin
                    if (conv_done) begin
                        tx.o_tx_start <= 1'b1;
                        tx.o_tx_data  <= frame_byte(idx, bcd);
                        state         <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    state <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (tx.i_tx_busy) begin
                        state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (!tx.i_tx_busy) begin
                        if (idx == LAST_IDX) begin
                            o_done <= 1'b1;
                            o_busy <= 1'b0;
                            idx    <= '0;
                            state  <= S_IDLE;
                        end else begin
                            idx           <= idx + IDX_W'(1);
                            tx.o_tx_start <= 1'b1;
                            tx.o_tx_data  <= frame_byte(idx + IDX_W'(1), bcd);
                            state         <= S_LOAD;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_time_reporter.sv
// Randomized bench for uart_time_reporter with a bench-side UART engine and event-level model.
module tb_uart_time_reporter;

    localparam int unsigned TIME_W = 24;
    localparam int unsigned MAXMS  = 9_999_999;

    logic              clk = 1'b0;
    logic              reset;
    logic              i_send;
    logic [TIME_W-1:0] i_time_ms;
    logic              o_busy;
    logic              o_done;
    logic              o_overrun;

    uart_time_reporter_if tx_if ();

    uart_time_reporter #(.TIME_W(TIME_W), .MAX_MS(MAXMS)) dut (
        .clk       (clk),
        .reset     (reset),
        .i_send    (i_send),
        .i_time_ms (i_time_ms),
        .tx        (tx_if),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_overrun (o_overrun)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // UART engine: busy rises the cycle after start and lasts eng_len cycles.
    logic       eng_busy  = 1'b0;
    int         eng_cnt   = 0;
    int         eng_len   = 40;
    int         bad_start = 0;
    logic [7:0] rx_q[$];

    assign tx_if.i_tx_busy = eng_busy;

    always @(posedge clk) begin
        if (tx_if.o_tx_start === 1'b1) begin
            if (eng_busy) bad_start <= bad_start + 1;
            eng_busy <= 1'b1;
            eng_cnt  <= eng_len;
            rx_q.push_back(tx_if.o_tx_data);
        end else if (eng_busy) begin
            if (eng_cnt <= 1) eng_busy <= 1'b0;
            eng_cnt <= eng_cnt - 1;
        end
    end

    // Event-level model: expected outputs for the cycle following each edge.
    logic [7:0] expq[$];
    logic       e_start = 0, e_done = 0, e_ovr = 0, e_busy = 0;
    logic [7:0] e_data = 0;
    int         conv_left = 0, sent = 0;
    bit         await_rise = 0, await_fall = 0, model_on = 0;
    bit         was_busy, start_now;

    function automatic void push_frame(input int unsigned t);
        int unsigned v;
        logic [7:0] d[7];
        v = (t > MAXMS) ? MAXMS : t;
        for (int k = 0; k < 7; k++) begin
            d[k] = 8'(v % 10);
            v = v / 10;
        end
        for (int k = 6; k >= 3; k--) expq.push_back(8'h30 + d[k]);
        expq.push_back(8'h2E);
        for (int k = 2; k >= 0; k--) expq.push_back(8'h30 + d[k]);
        expq.push_back(8'h0D);
        expq.push_back(8'h0A);
    endfunction

    task automatic issue();
        e_start = 1'b1;
        e_data  = (expq.size() > 0) ? expq.pop_front() : 8'hXX;
        sent++;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                e_start = 0; e_done = 0; e_ovr = 0; e_busy = 0; e_data = 0;
                conv_left = 0; sent = 0; await_rise = 0; await_fall = 0;
                expq.delete();
                model_on = 1;
            end else if (model_on) begin
                was_busy  = e_busy;
                start_now = e_start;
                e_ovr   = i_send && was_busy;
                e_start = 0;
                e_done  = 0;
                if (start_now) begin
                    await_rise = 1;
                end else if (await_rise && tx_if.i_tx_busy) begin
                    await_rise = 0;
                    await_fall = 1;
                end else if (await_fall && !tx_if.i_tx_busy) begin
                    await_fall = 0;
                    if (sent == 10) begin
                        e_done = 1;
                        e_busy = 0;
                    end else begin
                        issue();
                    end
                end
                if (!was_busy && i_send) begin
                    e_busy    = 1;
                    sent      = 0;
                    conv_left = TIME_W;
                    push_frame(int'(i_time_ms));
                end else if (conv_left > 0) begin
                    conv_left--;
                    if (conv_left == 0) issue();
                end
            end
        end
    end

    int done_cnt = 0;
    int ovr_cnt  = 0;

    // Per-cycle compare against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (model_on) begin
                chk("tx_start", tx_if.o_tx_start, e_start);
                chk("tx_data",  tx_if.o_tx_data,  e_data);
                chk("busy",     o_busy,           e_busy);
                chk("done",     o_done,           e_done);
                chk("overrun",  o_overrun,        e_ovr);
                if (o_done === 1'b1) done_cnt++;
                if (o_overrun === 1'b1) ovr_cnt++;
            end
        end
    end

    task automatic send(input logic [TIME_W-1:0] t);
        @(negedge clk);
        i_send    = 1'b1;
        i_time_ms = t;
        @(negedge clk);
        i_send    = 1'b0;
        i_time_ms = TIME_W'($urandom);
    endtask

    task automatic wait_done(input bit inject);
        bit ok;
        ok = 0;
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            if (o_done) begin ok = 1; break; end
            if (inject && o_busy && ($urandom_range(0, 40) == 0)) begin
                i_send    = 1'b1;
                i_time_ms = TIME_W'($urandom);
                @(negedge clk);
                i_send = 1'b0;
                if (o_done) begin ok = 1; break; end
            end
        end
        if (!ok) chk("done_timeout", 0, 1);
        else chk("eng_idle_at_done", eng_busy, 0);
    endtask

    task automatic chk_frame(input string name, input int base, input logic [7:0] lit[10]);
        if (rx_q.size() < base + 10) begin
            chk({name, "_len"}, rx_q.size(), base + 10);
        end else begin
            for (int i = 0; i < 10; i++) chk(name, rx_q[base+i], lit[i]);
        end
    endtask

    logic [7:0] f_1234567[10] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h2E, 8'h35, 8'h36, 8'h37, 8'h0D, 8'h0A};
    logic [7:0] f_zero[10]    = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h2E, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A};
    logic [7:0] f_max[10]     = '{8'h39, 8'h39, 8'h39, 8'h39, 8'h2E, 8'h39, 8'h39, 8'h39, 8'h0D, 8'h0A};
    logic [7:0] f_42[10]      = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h2E, 8'h30, 8'h34, 8'h32, 8'h0D, 8'h0A};
    logic [7:0] f_7654321[10] = '{8'h37, 8'h36, 8'h35, 8'h34, 8'h2E, 8'h33, 8'h32, 8'h31, 8'h0D, 8'h0A};

    initial begin
        int lat, d0, o0, n;
        int unsigned t;
        reset = 1'b1; i_send = 1'b0; i_time_ms = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", o_busy, 0);
        chk("rst_start", tx_if.o_tx_start, 0);
        chk("rst_data", tx_if.o_tx_data, 0);
        chk("rst_done", o_done, 0);
        chk("rst_overrun", o_overrun, 0);
        reset = 1'b0;

        // Typical frame with a 4-clocks-per-bit engine.
        rx_q.delete(); d0 = done_cnt;
        send(1_234_567);
        wait_done(0);
        chk("busy_after_lf", o_busy, 0);
        repeat (5) @(negedge clk);
        chk_frame("frame_1234567", 0, f_1234567);
        chk("done_pulses", done_cnt - d0, 1);

        // Zero with first-start latency measured from the i_send cycle.
        rx_q.delete();
        send(0);
        lat = 1;
        while (!tx_if.o_tx_start && lat < 200) begin @(negedge clk); lat++; end
        chk("first_start_latency", lat, 25);
        wait_done(0);
        chk_frame("frame_zero", 0, f_zero);

        // Saturation and the ceiling itself.
        rx_q.delete();
        send(24'hFFFFFF); wait_done(0);
        send(24'(MAXMS)); wait_done(0);
        chk_frame("frame_sat", 0, f_max);
        chk_frame("frame_max", 10, f_max);

        // Overrun during byte 3.
        rx_q.delete(); o0 = ovr_cnt;
        send(42);
        n = 0;
        while (rx_q.size() < 4 && n < 1000) begin @(negedge clk); n++; end
        chk("reach_byte3", rx_q.size(), 4);
        i_send = 1'b1; i_time_ms = 24'd5;
        @(negedge clk);
        i_send = 1'b0;
        wait_done(0);
        repeat (10) @(negedge clk);
        chk("overrun_pulses", ovr_cnt - o0, 1);
        chk("overrun_len", rx_q.size(), 10);
        chk_frame("frame_overrun", 0, f_42);

        // Reset while waiting on byte 5.
        rx_q.delete();
        send(7_654_321);
        n = 0;
        while (!(rx_q.size() == 6 && eng_busy) && n < 1000) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_busy", o_busy, 0);
        chk("midrst_start", tx_if.o_tx_start, 0);
        chk("midrst_data", tx_if.o_tx_data, 0);
        n = 0;
        while (eng_busy && n < 200) begin @(negedge clk); n++; end
        repeat (30) @(negedge clk);
        chk("midrst_no_more_bytes", rx_q.size(), 6);
        rx_q.delete();
        send(7_654_321); wait_done(0);
        chk_frame("frame_after_rst", 0, f_7654321);

        // Request in the o_done cycle is accepted back-to-back.
        rx_q.delete(); d0 = done_cnt; o0 = ovr_cnt;
        send(1_234_567);
        wait_done(0);
        i_send = 1'b1; i_time_ms = 24'd0;
        @(negedge clk);
        i_send = 1'b0;
        wait_done(0);
        chk("b2b_done_pulses", done_cnt - d0, 2);
        chk("b2b_overrun", ovr_cnt - o0, 0);
        chk_frame("b2b_frame1", 0, f_1234567);
        chk_frame("b2b_frame2", 10, f_zero);

        // Random times, engine lengths and overrun injections.
        for (int it = 0; it < 25; it++) begin
            eng_len = $urandom_range(1, 40);
            case ($urandom_range(0, 3))
                0: t = $urandom & 32'h00FF_FFFF;
                1: t = MAXMS + $urandom_range(0, 1000);
                2: t = $urandom_range(0, MAXMS);
                default: t = $urandom_range(0, 999);
            endcase
            rx_q.delete();
            send(TIME_W'(t));
            wait_done(1);
            chk("rand_len", rx_q.size(), 10);
        end

        repeat (10) @(negedge clk);
        chk("start_while_engine_busy", bad_start, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
